// File: rtl/fabric_reset_sequencer.sv
// -----------------------------------------------------------------------------
// fabric_reset_sequencer
//
// Produces staged, synchronously released resets for fabric logic that sits
// downstream of the MSS. The core domain is released first, then the
// peripheral domain. Release waits for PLL lock. A lock timeout raises a
// sticky fault. A rising edge on the software request forces a fixed-length
// reset pulse. Losing lock after release restarts the whole sequence.
//
// Ports
//   FAB_CLK         in   fabric clock, the only clock
//   MSS_RESET_N     in   asynchronous active-low reset from the MSS
//   PLL_LOCK        in   PLL lock, asynchronous to FAB_CLK
//   SW_RESET_REQ    in   software reset request level, asynchronous
//   CORE_RESET_N    out  registered active-low reset, core domain
//   PERIPH_RESET_N  out  registered active-low reset, peripheral domain
//   READY           out  high only in RUN
//   FAULT           out  high only in FAULT
//   STATE           out  current state encoding for debug/readback
// -----------------------------------------------------------------------------
module fabric_reset_sequencer #(
   parameter int SYNC_STAGES  = 2,
   parameter int LOCK_TIMEOUT = 1000,
   parameter int CORE_DELAY   = 16,
   parameter int PERIPH_DELAY = 32,
   parameter int SW_PULSE     = 8,
   parameter int CNT_W        = 16
) (
   input  logic       FAB_CLK,
   input  logic       MSS_RESET_N,
   input  logic       PLL_LOCK,
   input  logic       SW_RESET_REQ,
   output logic       CORE_RESET_N,
   output logic       PERIPH_RESET_N,
   output logic       READY,
   output logic       FAULT,
   output logic [2:0] STATE
);

   typedef enum logic [2:0] {
      S_WAIT_LOCK = 3'd0,
      S_STAGE1    = 3'd1,
      S_STAGE2    = 3'd2,
      S_RUN       = 3'd3,
      S_SW_RST    = 3'd4,
      S_FAULT     = 3'd5
   } state_t;

   // Terminal counts for each timed state, sized to the counter.
   localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_DELAY - 1);
   localparam logic [CNT_W-1:0] SW_LAST     = CNT_W'(SW_PULSE - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   logic [SYNC_STAGES-1:0] rst_sync_q;
   logic [SYNC_STAGES-1:0] lock_sync_q;
   logic [SYNC_STAGES-1:0] sw_sync_q;
   logic                   sw_prev_q;

   logic                   rst_rel;
   logic                   lock_s;
   logic                   sw_s;
   logic                   sw_edge;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   core_q, core_d;
   logic                   periph_q, periph_d;
   logic                   ready_q, ready_d;
   logic                   fault_q, fault_d;

   // Reset-release synchronizer plus the two input synchronizers. All are
   // cleared asynchronously; the reset chain shifts in ones so that the FSM
   // only starts moving once release has crossed into FAB_CLK.
   always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
      if (!MSS_RESET_N) begin
         rst_sync_q  <= '0;
         lock_sync_q <= '0;
         sw_sync_q   <= '0;
         sw_prev_q   <= 1'b0;
      end else begin
         rst_sync_q  <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
         lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], PLL_LOCK};
         sw_sync_q   <= {sw_sync_q[SYNC_STAGES-2:0], SW_RESET_REQ};
         sw_prev_q   <= sw_sync_q[SYNC_STAGES-1];
      end
   end

   assign rst_rel = rst_sync_q[SYNC_STAGES-1];
   assign lock_s  = lock_sync_q[SYNC_STAGES-1];
   assign sw_s    = sw_sync_q[SYNC_STAGES-1];
   assign sw_edge = sw_s & ~sw_prev_q;

   // State, counter and registered outputs.
   always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
      if (!MSS_RESET_N) begin
         state_q  <= S_WAIT_LOCK;
         cnt_q    <= '0;
         core_q   <= 1'b0;
         periph_q <= 1'b0;
         ready_q  <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         core_q   <= core_d;
         periph_q <= periph_d;
         ready_q  <= ready_d;
         fault_q  <= fault_d;
      end
   end

   // Next-state logic. Lock loss is checked before the software edge so it
   // wins when both arrive together. SW_RST ignores everything until its
   // pulse completes; FAULT only leaves on a software edge.
   always_comb begin
      state_d = state_q;
      if (rst_rel) begin
         case (state_q)
            S_WAIT_LOCK: begin
               if (lock_s)                  state_d = S_STAGE1;
               else if (cnt_q == LOCK_LAST) state_d = S_FAULT;
            end
            S_STAGE1: begin
               if (!lock_s)                 state_d = S_WAIT_LOCK;
               else if (sw_edge)            state_d = S_SW_RST;
               else if (cnt_q == CORE_LAST) state_d = S_STAGE2;
            end
            S_STAGE2: begin
               if (!lock_s)                   state_d = S_WAIT_LOCK;
               else if (sw_edge)              state_d = S_SW_RST;
               else if (cnt_q == PERIPH_LAST) state_d = S_RUN;
            end
            S_RUN: begin
               if (!lock_s)       state_d = S_WAIT_LOCK;
               else if (sw_edge)  state_d = S_SW_RST;
            end
            S_SW_RST: begin
               if (cnt_q == SW_LAST) state_d = S_WAIT_LOCK;
            end
            S_FAULT: begin
               if (sw_edge) state_d = S_WAIT_LOCK;
            end
            default: state_d = S_WAIT_LOCK;
         endcase
      end
   end

   // Counter restarts on every state change and saturates instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (!rst_rel || (state_d != state_q)) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Outputs are decoded from the next state so each release or assertion
   // lands on the same edge as the transition. Peripheral release is a
   // subset of core release, so the ordering can never invert.
   always_comb begin
      core_d   = 1'b0;
      periph_d = 1'b0;
      ready_d  = 1'b0;
      fault_d  = 1'b0;
      case (state_d)
         S_STAGE2: core_d = 1'b1;
         S_RUN: begin
            core_d   = 1'b1;
            periph_d = 1'b1;
            ready_d  = 1'b1;
         end
         S_FAULT: fault_d = 1'b1;
         default: ;
      endcase
   end

   assign CORE_RESET_N   = core_q;
   assign PERIPH_RESET_N = periph_q;
   assign READY          = ready_q;
   assign FAULT          = fault_q;
   assign STATE          = state_q;

endmodule

// File: tb/tb_fabric_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fabric_reset_sequencer
//
// Directed bench. Each stimulus step pushes the output transitions it should
// cause (output vector plus the clock cycle it must first be seen in) into a
// queue. A monitor samples outputs on the falling edge and, whenever they
// change, pops the oldest expectation and compares value and cycle. Any
// change with nothing queued is an error.
//
// Cycle numbering: cyc = number of rising edges so far. An input changed just
// after edge N is captured by the synchronizer on edge N+1, is visible as the
// synced value after edge N+2, and the FSM acts on edge N+3.
// -----------------------------------------------------------------------------
module tb_fabric_reset_sequencer;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       lock  = 1'b0;
   logic       sw    = 1'b0;
   logic       core_rst_n, periph_rst_n, ready, fault;
   logic [2:0] state;

   int cyc    = 0;
   int errs   = 0;
   int checks = 0;

   typedef struct {
      string      name;
      int         at;
      logic [6:0] vec;
   } exp_t;

   exp_t q[$];

   fabric_reset_sequencer #(
      .SYNC_STAGES (2),
      .LOCK_TIMEOUT(1000),
      .CORE_DELAY  (16),
      .PERIPH_DELAY(32),
      .SW_PULSE    (8),
      .CNT_W       (16)
   ) dut (
      .FAB_CLK       (clk),
      .MSS_RESET_N   (rst_n),
      .PLL_LOCK      (lock),
      .SW_RESET_REQ  (sw),
      .CORE_RESET_N  (core_rst_n),
      .PERIPH_RESET_N(periph_rst_n),
      .READY         (ready),
      .FAULT         (fault),
      .STATE         (state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [6:0] mk(input logic [2:0] st, input logic c, input logic p,
                                     input logic r, input logic f);
      return {st, c, p, r, f};
   endfunction

   task automatic push(input string name, input int at, input logic [6:0] vec);
      exp_t e;
      e.name = name;
      e.at   = at;
      e.vec  = vec;
      q.push_back(e);
   endtask

   // Returns just after rising edge c (cyc == c).
   task automatic wait_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_now(input string name, input logic [6:0] want);
      logic [6:0] cur;
      cur = {state, core_rst_n, periph_rst_n, ready, fault};
      checks++;
      if (cur !== want) begin
         errs++;
         $display("FAIL %s: got {state,core,periph,ready,fault}=%b required %b (cyc %0d)",
                  name, cur, want, cyc);
      end
   endtask

   // Monitor: compares every output change against the queue head.
   logic [6:0] prev = 7'b0;
   always @(negedge clk) begin
      logic [6:0] cur;
      exp_t       e;
      cur = {state, core_rst_n, periph_rst_n, ready, fault};
      if (cur !== prev) begin
         checks++;
         if (q.size() == 0) begin
            errs++;
            $display("FAIL unexpected_change: got %b at cyc %0d required no change from %b",
                     cur, cyc, prev);
         end else begin
            e = q.pop_front();
            if (cur !== e.vec || cyc != e.at) begin
               errs++;
               $display("FAIL %s: got %b at cyc %0d required %b at cyc %0d",
                        e.name, cur, cyc, e.vec, e.at);
            end
         end
         prev = cur;
      end
   end

   initial begin
      int n;
      int r;

      // Reset asserted with lock already high.
      #1 rst_n = 1'b0;
      lock = 1'b1;
      sw   = 1'b0;
      wait_to(3);
      check_now("reset_state", mk(3'd0, 0, 0, 0, 0));

      // Release: two edges of reset sync, FSM moves on the third edge.
      wait_to(10);
      n = cyc;
      rst_n = 1'b1;
      push("boot_stage1", n + 3,  mk(3'd1, 0, 0, 0, 0));
      push("boot_core",   n + 19, mk(3'd2, 1, 0, 0, 0));
      push("boot_run",    n + 51, mk(3'd3, 1, 1, 1, 0));
      wait_to(n + 60);
      check_now("boot_run_hold", mk(3'd3, 1, 1, 1, 0));

      // Lock lost and held low: WAIT_LOCK, then FAULT 1000 cycles later.
      n = cyc;
      lock = 1'b0;
      push("lock_lost",     n + 3,    mk(3'd0, 0, 0, 0, 0));
      push("timeout_fault", n + 1003, mk(3'd5, 0, 0, 0, 1));
      wait_to(n + 1010);
      lock = 1'b1;                 // must be ignored while faulted
      wait_to(n + 1040);
      check_now("fault_sticky", mk(3'd5, 0, 0, 0, 1));

      // Software edge clears FAULT, then a normal sequence follows.
      n = cyc;
      sw = 1'b1;
      push("fault_clear",  n + 3,  mk(3'd0, 0, 0, 0, 0));
      push("fc_stage1",    n + 4,  mk(3'd1, 0, 0, 0, 0));
      push("fc_core",      n + 20, mk(3'd2, 1, 0, 0, 0));
      push("fc_run",       n + 52, mk(3'd3, 1, 1, 1, 0));
      wait_to(n + 6);
      sw = 1'b0;
      wait_to(n + 60);

      // One-cycle lock drop in RUN, then full re-sequence.
      n = cyc;
      lock = 1'b0;
      push("blip_wait",   n + 3,  mk(3'd0, 0, 0, 0, 0));
      push("blip_stage1", n + 4,  mk(3'd1, 0, 0, 0, 0));
      push("blip_core",   n + 20, mk(3'd2, 1, 0, 0, 0));
      push("blip_run",    n + 52, mk(3'd3, 1, 1, 1, 0));
      wait_to(n + 1);
      lock = 1'b1;
      wait_to(n + 60);

      // Three-cycle SW pulse in RUN; a second rising edge lands inside SW_RST.
      n = cyc;
      sw = 1'b1;
      push("sw_rst",      n + 3,  mk(3'd4, 0, 0, 0, 0));
      push("sw_done",     n + 11, mk(3'd0, 0, 0, 0, 0));
      push("sw_stage1",   n + 12, mk(3'd1, 0, 0, 0, 0));
      push("sw_core",     n + 28, mk(3'd2, 1, 0, 0, 0));
      push("sw_run",      n + 60, mk(3'd3, 1, 1, 1, 0));
      wait_to(n + 3);
      sw = 1'b0;
      wait_to(n + 5);
      sw = 1'b1;                   // synced edge reaches the FSM on edge n+8
      wait_to(n + 70);
      sw = 1'b0;
      wait_to(n + 80);

      // Re-sequence to reach STAGE2.
      n = cyc;
      lock = 1'b0;
      push("pre_wait",   n + 3,  mk(3'd0, 0, 0, 0, 0));
      push("pre_stage1", n + 4,  mk(3'd1, 0, 0, 0, 0));
      push("pre_core",   n + 20, mk(3'd2, 1, 0, 0, 0));
      wait_to(n + 1);
      lock = 1'b1;
      wait_to(n + 25);

      // In STAGE2: lock loss and SW edge together; lock loss wins.
      n = cyc;
      lock = 1'b0;
      sw   = 1'b1;
      push("lockloss_beats_sw", n + 3, mk(3'd0, 0, 0, 0, 0));
      wait_to(n + 5);
      lock = 1'b1;
      push("both_stage1", n + 8,  mk(3'd1, 0, 0, 0, 0));
      push("both_core",   n + 24, mk(3'd2, 1, 0, 0, 0));
      wait_to(n + 30);
      check_now("both_in_stage2", mk(3'd2, 1, 0, 0, 0));

      // Asynchronous reset between clock edges while in STAGE2.
      n = cyc;
      sw = 1'b0;
      push("async_reset", n, mk(3'd0, 0, 0, 0, 0));
      #1 rst_n = 1'b0;
      #1 check_now("async_reset_no_edge", mk(3'd0, 0, 0, 0, 0));
      wait_to(n + 5);
      rst_n = 1'b1;
      r = cyc;
      push("rel_stage1", r + 3,  mk(3'd1, 0, 0, 0, 0));
      push("rel_core",   r + 19, mk(3'd2, 1, 0, 0, 0));
      push("rel_run",    r + 51, mk(3'd3, 1, 1, 1, 0));
      wait_to(r + 60);
      check_now("final_run", mk(3'd3, 1, 1, 1, 0));

      checks++;
      if (q.size() != 0) begin
         errs++;
         $display("FAIL pending_expectations: got %0d outstanding required 0 (next %s at cyc %0d)",
                  q.size(), q[0].name, q[0].at);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
